// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Time-multiplexed scan engine for a 4-digit FND. Each digit gets a slot of
//   DIV_CYCLES clocks: BLANK_CYCLES of forced-off dead time, then the digit is
//   lit. A new display value is held pending and only swapped in at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | scan_en low, display dark, digit 0 / counter 0 held
//   BLANK | first BLANK_CYCLES of a slot, display forced off
//   ON    | rest of the slot, current digit lit unless suppressed
//
// Ports
//   PCLK, PRESET : clock, synchronous active-high reset
//   scan_en      : run scanning (0 = idle, display off)
//   value_i      : 16-bit hex value, digit k = value_i[4k+3:4k]
//   value_valid  : one-cycle strobe capturing value_i
//   digit_en     : per-digit enable mask
//   lz_blank     : suppress leading zero digits (digit 0 never blanked)
//   fcr          : display enable
//   fmr          : one-hot digit select
//   fdr          : hex nibble of the current digit
//   digit_idx    : current digit index
//   frame_done   : one-cycle pulse following a frame boundary
//   pending      : a captured value is waiting for the next frame boundary
module fnd_scan_ctrl #(
  parameter int DIV_CYCLES   = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        scan_en,
  input  logic [15:0] value_i,
  input  logic        value_valid,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic        fcr,
  output logic [3:0]  fmr,
  output logic [3:0]  fdr,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic        pending
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_C   = CNT_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx_nxt;
  logic [15:0]      cur_value, cur_nxt;
  logic [15:0]      pend_value, pend_nxt;
  logic             pending_nxt;
  logic             frame_done_nxt;
  logic [15:0]      cur_shifted;
  logic             suppress;
  logic             fcr_nxt;
  logic [3:0]       fmr_nxt;
  logic [3:0]       fdr_nxt;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = digit_idx;
    cur_nxt        = cur_value;
    pend_nxt       = pend_value;
    pending_nxt    = pending;
    frame_done_nxt = 1'b0;

    if (state == IDLE) begin
      cnt_nxt = '0;
      idx_nxt = 2'd0;
      // While idle a strobe is visible immediately; a value left pending by
      // a mid-frame stop is flushed here.
      if (value_valid) begin
        cur_nxt     = value_i;
        pending_nxt = 1'b0;
      end else if (pending) begin
        cur_nxt     = pend_value;
        pending_nxt = 1'b0;
      end
      if (scan_en) begin
        state_nxt = (BLANK_C != '0) ? BLANK : ON;
      end
    end else begin
      if (value_valid) begin
        pend_nxt    = value_i;
        pending_nxt = 1'b1;
      end
      if (!scan_en) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end else begin
        if (cnt == SLOT_LAST) begin
          cnt_nxt = '0;
          idx_nxt = digit_idx + 2'd1;
          if (digit_idx == 2'd3) begin
            frame_done_nxt = 1'b1;
            // A strobe landing on the boundary itself bypasses pend_value.
            if (value_valid) begin
              cur_nxt     = value_i;
              pending_nxt = 1'b0;
            end else if (pending) begin
              cur_nxt     = pend_value;
              pending_nxt = 1'b0;
            end
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        state_nxt = (cnt_nxt < BLANK_C) ? BLANK : ON;
      end
    end
  end

  // Display outputs are registered from next-state values so they line up
  // with the state they describe and never see a combinational input path.
  always_comb begin
    cur_shifted = cur_nxt >> {idx_nxt, 2'b00};
    suppress    = !digit_en[idx_nxt] ||
                  (lz_blank && (idx_nxt != 2'd0) && (cur_shifted == 16'h0000));
    fcr_nxt     = (state_nxt == ON) && !suppress;
    fmr_nxt     = fcr_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
    fdr_nxt     = (state_nxt == IDLE) ? 4'h0 : cur_shifted[3:0];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= 2'd0;
      cur_value  <= 16'h0000;
      pend_value <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      fcr        <= 1'b0;
      fmr        <= 4'b0000;
      fdr        <= 4'h0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      cur_value  <= cur_nxt;
      pend_value <= pend_nxt;
      pending    <= pending_nxt;
      frame_done <= frame_done_nxt;
      fcr        <= fcr_nxt;
      fmr        <= fmr_nxt;
      fdr        <= fdr_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with DIV_CYCLES=8, BLANK_CYCLES=2. The reference
// model tracks scanning as a single position within a 32-cycle frame.
module tb_fnd_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        scan_en = 1'b0;
  logic [15:0] value_i = 16'h0000;
  logic        value_valid = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        fcr;
  logic [3:0]  fmr;
  logic [3:0]  fdr;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  fnd_scan_ctrl #(.DIV_CYCLES(DIV), .BLANK_CYCLES(BLK)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .scan_en(scan_en), .value_i(value_i),
    .value_valid(value_valid), .digit_en(digit_en), .lz_blank(lz_blank),
    .fcr(fcr), .fmr(fmr), .fdr(fdr), .digit_idx(digit_idx),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  bit          m_run;
  int          m_pos;
  logic [15:0] m_cur;
  logic [15:0] m_pend;
  bit          m_pending;
  bit          m_fd;
  bit          m_en_dig [4];
  bit          m_lz;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 4; k++) m_en_dig[k] = digit_en[k];
    m_lz = lz_blank;
    if (PRESET) begin
      m_run = 0; m_pos = 0; m_cur = 0; m_pend = 0; m_pending = 0; m_fd = 0;
    end else if (!m_run) begin
      m_fd = 0;
      if (value_valid) begin m_cur = value_i; m_pending = 0; end
      else if (m_pending) begin m_cur = m_pend; m_pending = 0; end
      if (scan_en) begin m_run = 1; m_pos = 0; end
    end else if (!scan_en) begin
      m_run = 0; m_pos = 0; m_fd = 0;
      if (value_valid) begin m_pend = value_i; m_pending = 1; end
    end else begin
      m_fd = (m_pos == FRAME - 1);
      if (m_fd) begin
        if (value_valid) begin m_cur = value_i; m_pending = 0; end
        else if (m_pending) begin m_cur = m_pend; m_pending = 0; end
      end else if (value_valid) begin
        m_pend = value_i; m_pending = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic compare_outputs();
    int d, c;
    bit lit;
    logic [3:0] e_fmr, e_fdr;
    logic [1:0] e_idx;
    lit = 0; e_fmr = 0; e_fdr = 0; e_idx = 0;
    if (m_run) begin
      d = m_pos / DIV;
      c = m_pos % DIV;
      e_idx = 2'(d);
      e_fdr = 4'((m_cur >> (4 * d)) & 16'hF);
      lit = (c >= BLK) && m_en_dig[d] && !(m_lz && d >= 1 && (m_cur >> (4 * d)) == 16'h0);
      if (lit) e_fmr = 4'(1 << d);
    end
    check_val("fcr", 16'(fcr), 16'(lit));
    check_val("fmr", 16'(fmr), 16'(e_fmr));
    check_val("fdr", 16'(fdr), 16'(e_fdr));
    check_val("digit_idx", 16'(digit_idx), 16'(e_idx));
    check_val("frame_done", 16'(frame_done), 16'(m_fd));
    check_val("pending", 16'(pending), 16'(m_pending));
  endtask

  task automatic step();
    @(posedge PCLK);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model sits at frame position target (bounded).
  task automatic run_to(input int target);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_run && m_pos == target) break;
      step();
    end
    check_val("run_to_idx", 16'(digit_idx), 16'(target / DIV));
  endtask

  task automatic load_value(input logic [15:0] v);
    value_i = v;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  initial begin
    m_run = 0; m_pos = 0; m_cur = 0; m_pend = 0; m_pending = 0; m_fd = 0; m_lz = 0;
    for (int k = 0; k < 4; k++) m_en_dig[k] = 1;

    // 1: reset, load in IDLE, plain scanning
    PRESET = 1'b1;
    run(2);
    PRESET = 1'b0;
    load_value(16'h1234);
    scan_en = 1'b1;
    run(70);

    // 2: new value during digit 1 waits for the frame boundary
    run_to(DIV + 3);
    load_value(16'hABCD);
    run(70);

    // 3: leading-zero blanking
    lz_blank = 1'b1;
    load_value(16'h0050);
    run(70);
    load_value(16'h0000);
    run(70);

    // 4: digit mask
    lz_blank = 1'b0;
    digit_en = 4'b1010;
    load_value(16'h1234);
    run(80);

    // 5: stop mid-slot, restart, reset mid-ON
    digit_en = 4'hF;
    run_to(2 * DIV + 5);
    scan_en = 1'b0;
    run(3);
    scan_en = 1'b1;
    run(20);
    run_to(2 * DIV + 4);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    load_value(16'h4321);
    run(20);

    // 6: strobe in the exact boundary cycle
    run_to(FRAME - 1);
    load_value(16'h5678);
    run(40);

    // random phase
    for (int i = 0; i < 5000; i++) begin
      value_valid = ($urandom_range(0, 7) == 0);
      value_i = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (scan_en) begin
        if ($urandom_range(0, 149) == 0) scan_en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        scan_en = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      PRESET = ($urandom_range(0, 1499) == 0);
      step();
    end
    PRESET = 1'b0;
    value_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
